rs232_avm_responder: RTL and testbench

//  Avalon-MM slave presenting the three-register RS232 map (RX data, TX data, STATUS) that our

---
 rtl/rs232_avm_responder_if.sv | 19 +
 rtl/rs232_avm_responder.sv | 173 +++++++++++++++++
 tb/tb_rs232_avm_responder.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs232_avm_responder_if.sv
// rtl/rs232_avm_responder_if.sv - Avalon-MM slave bus bundle for the RS232 register responder
interface rs232_avm_responder_if;
   logic [4:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;

   modport master (
      output avs_address, avs_read, avs_write, avs_writedata,
      input  avs_readdata, avs_waitrequest
   );

   modport slave (
      input  avs_address, avs_read, avs_write, avs_writedata,
      output avs_readdata, avs_waitrequest
   );
endinterface

// File: rtl/rs232_avm_responder.sv
// rtl/rs232_avm_responder.sv - RS232 RX/TX/STATUS register map over Avalon-MM with byte-stream FIFOs
// All register side effects happen on the edge that enters ACK, together with the readdata capture.
module rs232_avm_responder #(
   parameter int RX_DEPTH    = 16,
   parameter int TX_DEPTH    = 16,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                 avm_clk,
   input  logic                 avm_rst,
   rs232_avm_responder_if.slave avs,
   input  logic                 rx_valid,
   input  logic [7:0]           rx_data,
   output logic                 rx_ready,
   output logic                 tx_valid,
   output logic [7:0]           tx_data,
   input  logic                 tx_ready
);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam logic [RX_AW:0] RX_FULL = (RX_AW+1)'(RX_DEPTH);
   localparam logic [RX_AW:0] RX_ONE  = (RX_AW+1)'(1);
   localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);
   localparam logic [TX_AW:0] TX_ONE  = (TX_AW+1)'(1);
   localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
   localparam logic [4:0] ADDR_RX = 5'd0;
   localparam logic [4:0] ADDR_TX = 5'd4;
   localparam logic [4:0] ADDR_ST = 5'd8;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

   state_t          state_q, state_d;
   logic [3:0]      wait_cnt_q, wait_cnt_d;
   logic            cmd_rd_q, cmd_rd_d, cmd_wr_q, cmd_wr_d;
   logic [4:0]      cmd_addr_q, cmd_addr_d;
   logic [31:0]     readdata_q, readdata_d;
   logic            tx_ovf_q, tx_ovf_d;
   logic [7:0]      rx_mem_q [RX_DEPTH];
   logic [7:0]      rx_mem_d [RX_DEPTH];
   logic [RX_AW-1:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [RX_AW:0]  rx_cnt_q, rx_cnt_d;
   logic [7:0]      tx_mem_q [TX_DEPTH];
   logic [7:0]      tx_mem_d [TX_DEPTH];
   logic [TX_AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [TX_AW:0]  tx_cnt_q, tx_cnt_d;

   logic            cur_rd, cur_wr, enter_ack;
   logic [4:0]      cur_addr;
   logic            rx_push, rx_pop, tx_push, tx_pop, ovf_set, ovf_clr;
   logic            unused_wdata;

   assign rx_ready             = (rx_cnt_q != RX_FULL);
   assign tx_valid             = (tx_cnt_q != '0);
   assign tx_data              = tx_mem_q[tx_rd_q];
   assign avs.avs_waitrequest  = (state_q != S_ACK);
   assign avs.avs_readdata     = readdata_q;
   assign unused_wdata         = ^avs.avs_writedata[31:8];

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      cmd_rd_d   = cmd_rd_q;
      cmd_wr_d   = cmd_wr_q;
      cmd_addr_d = cmd_addr_q;
      readdata_d = 32'h0;
      cur_rd     = cmd_rd_q;
      cur_wr     = cmd_wr_q;
      cur_addr   = cmd_addr_q;

      case (state_q)
         S_IDLE: begin
            if (avs.avs_read || avs.avs_write) begin
               cmd_rd_d   = avs.avs_read;
               cmd_wr_d   = avs.avs_write & ~avs.avs_read;
               cmd_addr_d = avs.avs_address;
               cur_rd     = cmd_rd_d;
               cur_wr     = cmd_wr_d;
               cur_addr   = cmd_addr_d;
               wait_cnt_d = 4'd0;
               state_d    = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
            end
         end
         S_WAIT: begin
            wait_cnt_d = wait_cnt_q + 4'd1;
            if (wait_cnt_q == WAIT_LAST) state_d = S_ACK;
         end
         S_ACK:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // ACK is only ever entered from IDLE or WAIT, so this is exactly the accept edge
      enter_ack = (state_d == S_ACK);
      rx_pop    = enter_ack & cur_rd & (cur_addr == ADDR_RX) & (rx_cnt_q != '0);
      ovf_clr   = enter_ack & cur_rd & (cur_addr == ADDR_ST);
      tx_push   = enter_ack & cur_wr & (cur_addr == ADDR_TX) & (tx_cnt_q != TX_FULL);
      ovf_set   = enter_ack & cur_wr & (cur_addr == ADDR_TX) & (tx_cnt_q == TX_FULL);
      rx_push   = rx_valid & rx_ready;
      tx_pop    = tx_valid & tx_ready;
      tx_ovf_d  = (tx_ovf_q & ~ovf_clr) | ovf_set;

      if (enter_ack && cur_rd) begin
         if (cur_addr == ADDR_RX && rx_cnt_q != '0)
            readdata_d = {24'h0, rx_mem_q[rx_rd_q]};
         else if (cur_addr == ADDR_ST)
            readdata_d = {24'h0, rx_cnt_q != '0, tx_cnt_q != TX_FULL, 5'b0, tx_ovf_q};
      end

      rx_mem_d = rx_mem_q;
      rx_wr_d  = rx_wr_q;
      rx_rd_d  = rx_rd_q;
      rx_cnt_d = rx_cnt_q;
      if (rx_push) begin
         rx_mem_d[rx_wr_q] = rx_data;
         rx_wr_d           = rx_wr_q + 1'b1;
      end
      if (rx_pop) rx_rd_d = rx_rd_q + 1'b1;
      case ({rx_push, rx_pop})
         2'b10:   rx_cnt_d = rx_cnt_q + RX_ONE;
         2'b01:   rx_cnt_d = rx_cnt_q - RX_ONE;
         default: rx_cnt_d = rx_cnt_q;
      endcase

      tx_mem_d = tx_mem_q;
      tx_wr_d  = tx_wr_q;
      tx_rd_d  = tx_rd_q;
      tx_cnt_d = tx_cnt_q;
      if (tx_push) begin
         tx_mem_d[tx_wr_q] = avs.avs_writedata[7:0];
         tx_wr_d           = tx_wr_q + 1'b1;
      end
      if (tx_pop) tx_rd_d = tx_rd_q + 1'b1;
      case ({tx_push, tx_pop})
         2'b10:   tx_cnt_d = tx_cnt_q + TX_ONE;
         2'b01:   tx_cnt_d = tx_cnt_q - TX_ONE;
         default: tx_cnt_d = tx_cnt_q;
      endcase
   end

   always_ff @(posedge avm_clk or posedge avm_rst) begin
      if (avm_rst) begin
         state_q    <= S_IDLE;
         wait_cnt_q <= 4'd0;
         cmd_rd_q   <= 1'b0;
         cmd_wr_q   <= 1'b0;
         cmd_addr_q <= 5'd0;
         readdata_q <= 32'h0;
         tx_ovf_q   <= 1'b0;
         rx_mem_q   <= '{default: 8'h00};
         rx_wr_q    <= '0;
         rx_rd_q    <= '0;
         rx_cnt_q   <= '0;
         tx_mem_q   <= '{default: 8'h00};
         tx_wr_q    <= '0;
         tx_rd_q    <= '0;
         tx_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         cmd_rd_q   <= cmd_rd_d;
         cmd_wr_q   <= cmd_wr_d;
         cmd_addr_q <= cmd_addr_d;
         readdata_q <= readdata_d;
         tx_ovf_q   <= tx_ovf_d;
         rx_mem_q   <= rx_mem_d;
         rx_wr_q    <= rx_wr_d;
         rx_rd_q    <= rx_rd_d;
         rx_cnt_q   <= rx_cnt_d;
         tx_mem_q   <= tx_mem_d;
         tx_wr_q    <= tx_wr_d;
         tx_rd_q    <= tx_rd_d;
         tx_cnt_q   <= tx_cnt_d;
      end
   end
endmodule

// File: tb/tb_rs232_avm_responder.sv
// tb/tb_rs232_avm_responder.sv - randomized self-checking bench with queue-based register/FIFO model
module tb_rs232_avm_responder;
   localparam int W     = 2;
   localparam int DEPTH = 16;

   logic       avm_clk = 1'b0;
   logic       avm_rst = 1'b1;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_ready;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready = 1'b0;
   int         tx_mode = 0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] rx_src[$];
   logic [7:0] rx_q[$];
   logic [7:0] tx_exp[$];
   logic [7:0] tx_seen[$];
   bit         ovf_m = 1'b0;

   always #5 avm_clk = ~avm_clk;

   rs232_avm_responder_if bus();

   rs232_avm_responder #(.RX_DEPTH(DEPTH), .TX_DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
      .avm_clk  (avm_clk),
      .avm_rst  (avm_rst),
      .avs      (bus),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rx_ready (rx_ready),
      .tx_valid (tx_valid),
      .tx_data  (tx_data),
      .tx_ready (tx_ready)
   );

   function automatic logic [7:0] st_model();
      int occ = tx_exp.size() - tx_seen.size();
      return {rx_q.size() != 0, occ < DEPTH, 5'b0, ovf_m};
   endfunction

   // downstream sink: mode 0 stalls, 1 random ready, 2 one pop then stall
   initial begin
      forever begin
         @(posedge avm_clk); #1;
         case (tx_mode)
            1:       tx_ready = 1'($urandom_range(0, 1));
            2:       begin tx_ready = 1'b1; tx_mode = 0; end
            default: tx_ready = 1'b0;
         endcase
         if (tx_valid && tx_ready) tx_seen.push_back(tx_data);
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog simulation time exceeded, required completion");
      $fatal(1);
   end

   task automatic bus_xfer(input bit is_rd, input logic [4:0] addr, input logic [7:0] wdata,
                           output logic [31:0] rdata);
      int cyc = 0;
      bus.avs_address   = addr;
      bus.avs_read      = is_rd;
      bus.avs_write     = !is_rd;
      bus.avs_writedata = {24'($urandom), wdata};
      do begin
         @(posedge avm_clk); #1;
         cyc++;
      end while (bus.avs_waitrequest && cyc < 100);
      n_checks++;
      if (bus.avs_waitrequest !== 1'b0) begin
         n_fail++;
         $display("FAIL bus_timeout addr=%0d waitrequest=%b required 0", addr, bus.avs_waitrequest);
      end
      rdata         = bus.avs_readdata;
      bus.avs_read  = 1'b0;
      bus.avs_write = 1'b0;
   endtask

   task automatic feed_rx();
      int guard = 0;
      bit acc;
      while (rx_src.size() > 0 && guard < 3000) begin
         rx_valid = 1'b1;
         rx_data  = rx_src[0];
         acc      = rx_ready;
         @(posedge avm_clk); #1;
         if (acc) rx_q.push_back(rx_src.pop_front());
         guard++;
      end
      rx_valid = 1'b0;
      n_checks++;
      if (rx_src.size() != 0) begin
         n_fail++;
         $display("FAIL rx_feed_timeout left=%0d required 0", rx_src.size());
         rx_src.delete();
      end
   endtask

   task automatic test_reset();
      logic [31:0] r;
      repeat (3) @(posedge avm_clk);
      #1;
      n_checks++;
      if ({bus.avs_waitrequest, bus.avs_readdata, rx_ready, tx_valid, tx_data} !== {1'b1, 32'h0, 1'b1, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL reset_in wr=%b rd=%h rxr=%b txv=%b txd=%h required 1 0 1 0 0",
                  bus.avs_waitrequest, bus.avs_readdata, rx_ready, tx_valid, tx_data);
      end
      avm_rst = 1'b0;
      @(posedge avm_clk); #1;
      n_checks++;
      if ({bus.avs_waitrequest, bus.avs_readdata, rx_ready, tx_valid} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_out wr=%b rd=%h rxr=%b txv=%b required 1 0 1 0",
                  bus.avs_waitrequest, bus.avs_readdata, rx_ready, tx_valid);
      end
      bus_xfer(1'b1, 5'd8, 8'h00, r);
      n_checks++;
      if (r !== 32'h40) begin n_fail++; $display("FAIL reset_status got=%h required 00000040", r); end
   endtask

   task automatic test_rx_path();
      logic [31:0] r;
      logic [7:0]  e;
      rx_src.push_back(8'hA5);
      feed_rx();
      bus_xfer(1'b1, 5'd8, 8'h00, r);
      n_checks++;
      if (r !== {24'h0, st_model()} || r !== 32'hC0) begin n_fail++; $display("FAIL rx_status_full got=%h required 000000c0", r); end
      ovf_m = 1'b0;
      e = rx_q.pop_front();
      bus_xfer(1'b1, 5'd0, 8'h00, r);
      n_checks++;
      if (r !== {24'h0, e}) begin n_fail++; $display("FAIL rx_read got=%h required %h", r, e); end
      bus_xfer(1'b1, 5'd8, 8'h00, r);
      n_checks++;
      if (r !== {24'h0, st_model()}) begin n_fail++; $display("FAIL rx_status_empty got=%h required %h", r, st_model()); end
      bus_xfer(1'b1, 5'd0, 8'h00, r);
      n_checks++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL rx_read_empty got=%h required 0", r); end
      bus_xfer(1'b1, 5'd4, 8'h00, r);
      n_checks++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL read_tx_addr got=%h required 0", r); end
   endtask

   task automatic test_tx_path();
      logic [31:0] r;
      logic [7:0]  b;
      int          guard;
      tx_exp.delete(); tx_seen.delete(); tx_mode = 0;
      bus_xfer(1'b0, 5'd4, 8'h3C, r);
      tx_exp.push_back(8'h3C);
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h3C) begin
         n_fail++; $display("FAIL tx_first valid=%b data=%h required 1 3c", tx_valid, tx_data);
      end
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         if (tx_exp.size() - tx_seen.size() < DEPTH) tx_exp.push_back(b);
         else ovf_m = 1'b1;
         bus_xfer(1'b0, 5'd4, b, r);
      end
      bus_xfer(1'b0, 5'd8, 8'hFF, r);
      bus_xfer(1'b1, 5'd8, 8'h00, r);
      n_checks++;
      if (r !== {24'h0, st_model()}) begin n_fail++; $display("FAIL tx_status_ovf got=%h required %h", r, st_model()); end
      ovf_m = 1'b0;
      tx_mode = 2;
      guard = 0;
      while (tx_seen.size() < 1 && guard < 50) begin @(posedge avm_clk); #1; guard++; end
      repeat (2) @(posedge avm_clk);
      #1;
      bus_xfer(1'b1, 5'd8, 8'h00, r);
      n_checks++;
      if (r !== {24'h0, st_model()}) begin n_fail++; $display("FAIL tx_status_after_pop got=%h required %h", r, st_model()); end
      tx_mode = 1;
      guard = 0;
      while (tx_seen.size() < tx_exp.size() && guard < 1000) begin @(posedge avm_clk); #1; guard++; end
      tx_mode = 0;
      n_checks++;
      if (tx_seen != tx_exp) begin n_fail++; $display("FAIL tx_drain seen=%0d bytes required %0d in order", tx_seen.size(), tx_exp.size()); end
   endtask

   task automatic test_timing();
      int         next_ack;
      bit         is_ack;
      logic [7:0] exp_st;
      @(posedge avm_clk); #1;
      exp_st           = st_model();
      bus.avs_address  = 5'd8;
      bus.avs_read     = 1'b1;
      next_ack         = 1 + W;
      for (int k = 1; k <= 16; k++) begin
         @(posedge avm_clk); #1;
         is_ack = (k == next_ack);
         n_checks++;
         if (bus.avs_waitrequest !== !is_ack) begin
            n_fail++; $display("FAIL timing_wr cycle=%0d got=%b required %b", k, bus.avs_waitrequest, !is_ack);
         end
         n_checks++;
         if (bus.avs_readdata !== (is_ack ? {24'h0, exp_st} : 32'h0)) begin
            n_fail++; $display("FAIL timing_rd cycle=%0d got=%h required %h", k, bus.avs_readdata, is_ack ? exp_st : 8'h00);
         end
         if (is_ack) next_ack = k + 2 + W;
      end
      bus.avs_read = 1'b0;
      @(posedge avm_clk); #1;
   endtask

   task automatic test_concurrency();
      logic [31:0] r;
      logic [7:0]  e;
      for (int i = 0; i < 64; i++) rx_src.push_back(8'($urandom));
      fork
         feed_rx();
         begin
            int guard = 0;
            while (rx_ready && guard < 200) begin @(posedge avm_clk); #1; guard++; end
            n_checks++;
            if (rx_q.size() != DEPTH || rx_ready !== 1'b0) begin
               n_fail++; $display("FAIL conc_full rx_ready=%b model=%0d required 0 %0d", rx_ready, rx_q.size(), DEPTH);
            end
            for (int i = 0; i < 64; i++) begin
               guard = 0;
               do begin bus_xfer(1'b1, 5'd8, 8'h00, r); guard++; end while (!r[7] && guard < 50);
               e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hXX;
               bus_xfer(1'b1, 5'd0, 8'h00, r);
               n_checks++;
               if (r !== {24'h0, e}) begin n_fail++; $display("FAIL conc_byte idx=%0d got=%h required %h", i, r, e); end
            end
         end
      join
      bus_xfer(1'b1, 5'd8, 8'h00, r);
      n_checks++;
      if (r !== {24'h0, st_model()}) begin n_fail++; $display("FAIL conc_status got=%h required %h", r, st_model()); end
   endtask

   task automatic test_end_to_end();
      logic [31:0] r;
      logic [7:0]  got[$];
      logic [7:0]  e;
      int          guard = 0;
      tx_exp.delete(); tx_seen.delete(); tx_mode = 1;
      for (int i = 0; i < 64; i++) rx_src.push_back(8'($urandom));
      fork
         feed_rx();
         begin
            while ((got.size() < 64 || tx_exp.size() < 31) && guard < 3000) begin
               guard++;
               bus_xfer(1'b1, 5'd8, 8'h00, r);
               if (r[7] && got.size() < 64) begin
                  e = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hXX;
                  bus_xfer(1'b1, 5'd0, 8'h00, r);
                  n_checks++;
                  if (r !== {24'h0, e}) begin n_fail++; $display("FAIL e2e_rx idx=%0d got=%h required %h", got.size(), r, e); end
                  got.push_back(r[7:0]);
               end else if (r[6] && tx_exp.size() < 31 && tx_exp.size() < got.size()) begin
                  e = got[tx_exp.size()] ^ 8'h5A;
                  tx_exp.push_back(e);
                  bus_xfer(1'b0, 5'd4, e, r);
               end
            end
         end
      join
      guard = 0;
      while (tx_seen.size() < 31 && guard < 1000) begin @(posedge avm_clk); #1; guard++; end
      tx_mode = 0;
      n_checks++;
      if (tx_seen != tx_exp || tx_exp.size() != 31) begin
         n_fail++; $display("FAIL e2e_tx seen=%0d sent=%0d required 31 identical bytes", tx_seen.size(), tx_exp.size());
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r;
      logic [7:0]  e;
      int          guard = 0;
      tx_mode = 0; tx_exp.delete(); tx_seen.delete();
      for (int i = 0; i < 5; i++) rx_src.push_back(8'($urandom));
      feed_rx();
      for (int i = 0; i < 3; i++) bus_xfer(1'b0, 5'd4, 8'($urandom), r);
      bus.avs_address = 5'd0;
      bus.avs_read    = 1'b1;
      @(posedge avm_clk); #1;
      avm_rst      = 1'b1;
      bus.avs_read = 1'b0;
      repeat (2) @(posedge avm_clk);
      #1;
      avm_rst = 1'b0;
      rx_q.delete(); tx_exp.delete(); tx_seen.delete(); ovf_m = 1'b0;
      @(posedge avm_clk); #1;
      n_checks++;
      if ({bus.avs_waitrequest, bus.avs_readdata, rx_ready, tx_valid, tx_data} !== {1'b1, 32'h0, 1'b1, 1'b0, 8'h00}) begin
         n_fail++;
         $display("FAIL midreset_out wr=%b rd=%h rxr=%b txv=%b txd=%h required 1 0 1 0 0",
                  bus.avs_waitrequest, bus.avs_readdata, rx_ready, tx_valid, tx_data);
      end
      bus_xfer(1'b1, 5'd8, 8'h00, r);
      n_checks++;
      if (r !== {24'h0, st_model()}) begin n_fail++; $display("FAIL midreset_status got=%h required %h", r, st_model()); end
      bus_xfer(1'b1, 5'd0, 8'h00, r);
      n_checks++;
      if (r !== 32'h0) begin n_fail++; $display("FAIL midreset_rx_empty got=%h required 0", r); end
      for (int i = 0; i < 3; i++) rx_src.push_back(8'($urandom));
      feed_rx();
      for (int i = 0; i < 3; i++) begin
         e = rx_q.pop_front();
         bus_xfer(1'b1, 5'd0, 8'h00, r);
         n_checks++;
         if (r !== {24'h0, e}) begin n_fail++; $display("FAIL session2_rx idx=%0d got=%h required %h", i, r, e); end
      end
      tx_mode = 1;
      tx_exp.push_back(8'h77);
      bus_xfer(1'b0, 5'd4, 8'h77, r);
      while (tx_seen.size() < 1 && guard < 200) begin @(posedge avm_clk); #1; guard++; end
      tx_mode = 0;
      n_checks++;
      if (tx_seen != tx_exp) begin n_fail++; $display("FAIL session2_tx seen=%0d bytes required 1 byte 77", tx_seen.size()); end
   endtask

   initial begin
      bus.avs_address   = 5'd0;
      bus.avs_read      = 1'b0;
      bus.avs_write     = 1'b0;
      bus.avs_writedata = 32'h0;
      test_reset();
      test_rx_path();
      test_tx_path();
      test_timing();
      test_concurrency();
      test_end_to_end();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
